axi4l_timer: RTL and testbench

AXI4-Lite slave implementing the RISC-V machine timer (mtime/mtimecmp) for the Ibex SoC. Sits directly downstream of the AXI4-Lite crossbar on one slave port and drives the core's timer interrupt. Provides a programmable prescaler, a 64-bit free-running counter and a 64-bit compare register with a level interrupt.

---
 rtl/axi4l_timer_if.sv | 50 +++++
 rtl/axi4l_timer.sv | 150 +++++++++++++++
 tb/tb_axi4l_timer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_timer_if.sv
// AXI4-Lite type package and bus interface shared by the timer and its master.
package axi4l_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef logic [1:0]        resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axi4l_if;
    import axi4l_pkg::*;

    addr_t       awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    data_t       wdata;
    strb_t       wstrb;
    logic        wvalid;
    logic        wready;
    resp_t       bresp;
    logic        bvalid;
    logic        bready;
    addr_t       araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    data_t       rdata;
    resp_t       rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_timer.sv
// axi4l_timer: RISC-V machine timer (mtime/mtimecmp) with prescaler behind an AXI4-Lite slave.
module axi4l_timer
    import axi4l_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RST = 32'd99,
    parameter int          ADDR_LSB     = 2
) (
    input  logic   aclk,
    input  logic   aresetn,
    axi4l_if.slave axis,
    output logic   timer_irq
);
    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] prescale;
    logic [31:0] pcnt;
    logic        tick;
    logic        bvalid;
    logic        rvalid;
    resp_t       bresp;
    resp_t       rresp;
    data_t       rdata;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  wr_off;
    logic [2:0]  rd_off;
    data_t       rd_mux;
    logic        rd_hit;
    logic        wr_mlo, wr_mhi, wr_clo, wr_chi, wr_psc;
    logic        unused_ok;

    // Merge write data into a register under the byte strobes.
    function automatic data_t apply_strb(input data_t cur, input data_t wd, input strb_t strb);
        data_t res;
        res = cur;
        for (int i = 0; i < STRB_W; i++)
            if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
        return res;
    endfunction

    assign wr_off = axis.awaddr[ADDR_LSB+2:ADDR_LSB];
    assign rd_off = axis.araddr[ADDR_LSB+2:ADDR_LSB];

    // AW and W are only taken together, and never while a write response is pending.
    assign wr_en = axis.awvalid & axis.wvalid & ~bvalid;
    assign rd_en = axis.arvalid & ~rvalid;
    assign tick  = (pcnt == prescale);

    assign wr_mlo = wr_en & (wr_off == OFF_MTIME_LO);
    assign wr_mhi = wr_en & (wr_off == OFF_MTIME_HI);
    assign wr_clo = wr_en & (wr_off == OFF_CMP_LO);
    assign wr_chi = wr_en & (wr_off == OFF_CMP_HI);
    assign wr_psc = wr_en & (wr_off == OFF_PRESCALE);

    assign axis.awready = wr_en;
    assign axis.wready  = wr_en;
    assign axis.bvalid  = bvalid;
    assign axis.bresp   = bresp;
    assign axis.arready = ~rvalid;
    assign axis.rvalid  = rvalid;
    assign axis.rdata   = rdata;
    assign axis.rresp   = rresp;

    // Protection bits and upper address bits carry no meaning for this slave.
    assign unused_ok = ^{axis.awprot, axis.arprot, axis.awaddr, axis.araddr};

    // Prescaler: one tick every prescale+1 cycles; a PRESCALE write restarts the phase.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prescale <= PRESCALE_RST;
            pcnt     <= '0;
        end else if (wr_psc) begin
            prescale <= apply_strb(prescale, axis.wdata, axis.wstrb);
            pcnt     <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 32'd1;
        end
    end

    // mtime: a software write to either half wins over, and swallows, that cycle's tick.
    always_ff @(posedge aclk) begin
        if (!aresetn)     mtime         <= '0;
        else if (wr_mlo)  mtime[31:0]   <= apply_strb(mtime[31:0], axis.wdata, axis.wstrb);
        else if (wr_mhi)  mtime[63:32]  <= apply_strb(mtime[63:32], axis.wdata, axis.wstrb);
        else if (tick)    mtime         <= mtime + 64'd1;
    end

    // mtimecmp: resets to all-ones so the interrupt stays quiet until software arms it.
    always_ff @(posedge aclk) begin
        if (!aresetn)     mtimecmp        <= '1;
        else if (wr_clo)  mtimecmp[31:0]  <= apply_strb(mtimecmp[31:0], axis.wdata, axis.wstrb);
        else if (wr_chi)  mtimecmp[63:32] <= apply_strb(mtimecmp[63:32], axis.wdata, axis.wstrb);
    end

    // Level interrupt, registered from the current register contents.
    always_ff @(posedge aclk) begin
        if (!aresetn) timer_irq <= 1'b0;
        else          timer_irq <= (mtime >= mtimecmp);
    end

    // Write response: raised the cycle after acceptance, held until the master takes it.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (wr_en) begin
            bvalid <= 1'b1;
            bresp  <= (wr_off <= OFF_PRESCALE) ? RESP_OKAY : RESP_SLVERR;
        end else if (axis.bready) begin
            bvalid <= 1'b0;
        end
    end

    // Read mux sees pre-write values, so a same-cycle write is not reflected.
    always_comb begin
        rd_mux = '0;
        rd_hit = 1'b1;
        case (rd_off)
            OFF_MTIME_LO: rd_mux = mtime[31:0];
            OFF_MTIME_HI: rd_mux = mtime[63:32];
            OFF_CMP_LO:   rd_mux = mtimecmp[31:0];
            OFF_CMP_HI:   rd_mux = mtimecmp[63:32];
            OFF_PRESCALE: rd_mux = prescale;
            default:      rd_hit = 1'b0;
        endcase
    end

    // Read response: data captured at acceptance and held stable until rready.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (rd_en) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
            rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (axis.rready) begin
            rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4l_timer.sv
// Bench for axi4l_timer: directed steps plus random traffic against an arithmetic timer model.
module tb_axi4l_timer;
    import axi4l_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic timer_irq;
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;

    axi4l_if bus();

    axi4l_timer #(.PRESCALE_RST(32'd99), .ADDR_LSB(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .axis(bus), .timer_irq(timer_irq)
    );

    always #5 aclk = ~aclk;

    // Cycle index since reset release: cycle 0 is the first cycle with aresetn high.
    always @(posedge aclk) cyc <= aresetn ? cyc + 1 : 0;

    // Model: mtime(t) = m_val + ticks in cycles [m_cyc+1, t-1]; ticks fall every p_m+1
    // cycles counted from cycle p_anchor+1.
    logic [63:0] m_val, cmp_m, cmp_prev;
    logic [31:0] p_m;
    longint      m_cyc, p_anchor, cmp_cyc;

    function automatic longint ticks(input longint t);
        longint n;
        n = t - 1 - p_anchor;
        return (n <= 0) ? 0 : n / (longint'(p_m) + 1);
    endfunction

    function automatic logic [63:0] mtime_m(input longint t);
        return m_val + 64'(ticks(t) - ticks(m_cyc + 1));
    endfunction

    function automatic logic [63:0] cmp_at(input longint t);
        return (t >= cmp_cyc) ? cmp_m : cmp_prev;
    endfunction

    function automatic logic irq_exp(input longint t);
        return mtime_m(t - 1) >= cmp_at(t - 1);
    endfunction

    function automatic logic [31:0] bytes_merge(input logic [31:0] old, input logic [31:0] nw,
                                                input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic logic [31:0] reg_m(input logic [2:0] off, input longint t);
        logic [63:0] m, c;
        m = mtime_m(t);
        c = cmp_at(t);
        case (off)
            3'd0:    return m[31:0];
            3'd1:    return m[63:32];
            3'd2:    return c[31:0];
            3'd3:    return c[63:32];
            3'd4:    return p_m;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_val = '0; m_cyc = -1; p_anchor = -1; p_m = 32'd99;
        cmp_m = '1; cmp_prev = '1; cmp_cyc = 0;
    endtask

    // Apply a write accepted at the edge ending cycle n.
    task automatic model_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s,
                               input longint n);
        logic [63:0] cur;
        cur = mtime_m(n);
        case (off)
            3'd0: begin m_val = {cur[63:32], bytes_merge(cur[31:0], d, s)}; m_cyc = n; end
            3'd1: begin m_val = {bytes_merge(cur[63:32], d, s), cur[31:0]}; m_cyc = n; end
            3'd2: begin cmp_prev = cmp_m; cmp_m[31:0] = bytes_merge(cmp_m[31:0], d, s); cmp_cyc = n + 1; end
            3'd3: begin cmp_prev = cmp_m; cmp_m[63:32] = bytes_merge(cmp_m[63:32], d, s); cmp_cyc = n + 1; end
            3'd4: begin
                m_val = mtime_m(n + 1); m_cyc = n; p_anchor = n;
                p_m = bytes_merge(p_m, d, s);
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one cycle and check the interrupt level against the model.
    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
        if (aresetn && cyc >= 1 && longint'(cyc) - 2 >= m_cyc)
            chk("irq", 64'(timer_irq), 64'(irq_exp(cyc)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic axi_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s,
                             input int hold);
        resp_t er;
        er = (off <= 3'd4) ? RESP_OKAY : RESP_SLVERR;
        bus.awaddr = {27'd0, off, 2'b00}; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        #1;
        chk("awready", 64'(bus.awready), 64'd1);
        chk("wready", 64'(bus.wready), 64'd1);
        model_write(off, d, s, longint'(cyc));
        step();
        chk("bvalid", 64'(bus.bvalid), 64'd1);
        chk("bresp", 64'(bus.bresp), 64'(er));
        for (int i = 0; i < hold; i++) begin
            #1;
            chk("awready_bp", 64'(bus.awready), 64'd0);
            step();
            chk("bvalid_bp", 64'(bus.bvalid), 64'd1);
            chk("bresp_bp", 64'(bus.bresp), 64'(er));
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk("bvalid_clr", 64'(bus.bvalid), 64'd0);
    endtask

    task automatic axi_read(input logic [2:0] off, input int hold, output logic [31:0] d,
                            output longint r);
        logic [31:0] ed;
        resp_t er;
        bus.araddr = {27'd0, off, 2'b00}; bus.arvalid = 1'b1;
        #1;
        chk("arready", 64'(bus.arready), 64'd1);
        r  = longint'(cyc);
        ed = reg_m(off, r);
        er = (off <= 3'd4) ? RESP_OKAY : RESP_SLVERR;
        step();
        bus.arvalid = 1'b0;
        d = bus.rdata;
        chk("rvalid", 64'(bus.rvalid), 64'd1);
        chk("rdata", 64'(bus.rdata), 64'(ed));
        chk("rresp", 64'(bus.rresp), 64'(er));
        for (int i = 0; i < hold; i++) begin
            bus.arvalid = 1'b1;
            #1;
            chk("arready_bp", 64'(bus.arready), 64'd0);
            step();
            chk("rvalid_bp", 64'(bus.rvalid), 64'd1);
            chk("rdata_bp", 64'(bus.rdata), 64'(ed));
        end
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        chk("rvalid_clr", 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        logic [31:0] d1, d2, old_lo, wd;
        logic [63:0] tmp;
        longint      r1, r2;
        logic [2:0]  off;
        int          guard;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        model_reset();

        // Reset and reset values.
        @(negedge aclk);
        idle(3);
        aresetn = 1'b1;
        #1;
        chk("rst_awready", 64'(bus.awready), 64'd0);
        chk("rst_arready", 64'(bus.arready), 64'd1);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_resp", 64'({bus.bresp, bus.rresp}), 64'd0);
        chk("rst_irq", 64'(timer_irq), 64'd0);

        // First tick at cycle 99: arm compare at 1 so the irq pins the exact tick cycle.
        axi_write(3'd3, 32'd0, 4'hF, 0);
        axi_write(3'd2, 32'd1, 4'hF, 0);
        for (guard = 0; guard < 200 && cyc < 99; guard++) step();
        axi_read(3'd0, 0, d1, r1);
        chk("first_tick_pre", 64'(d1), 64'd0);
        axi_read(3'd0, 0, d1, r1);
        chk("first_tick_post", 64'(d1), 64'd1);
        axi_read(3'd4, 0, d1, r1);
        chk("prescale_rst", 64'(d1), 64'd99);

        // PRESCALE=0: mtime advances one per cycle.
        axi_write(3'd4, 32'd0, 4'hF, 0);
        axi_read(3'd0, 0, d1, r1);
        idle(8);
        axi_read(3'd0, 0, d2, r2);
        chk("lo_delta", 64'(d2 - d1), 64'(r2 - r1));
        chk("lo_delta10", 64'(r2 - r1), 64'd10);

        // Interrupt rises one cycle after mtime reaches 20, falls after compare is raised.
        axi_write(3'd0, 32'd0, 4'hF, 0);
        axi_write(3'd3, 32'd0, 4'hF, 0);
        axi_write(3'd2, 32'd20, 4'hF, 0);
        for (guard = 0; guard < 100 && mtime_m(cyc) != 64'd20; guard++) step();
        if (guard >= 100) begin
            n_bad++;
            $display("FAIL mtime20_wait: bound of 100 cycles expired");
        end
        chk("irq_pre", 64'(timer_irq), 64'd0);
        step();
        chk("irq_rise", 64'(timer_irq), 64'd1);
        axi_write(3'd2, 32'hFFFF_FFFF, 4'hF, 0);
        chk("irq_fall", 64'(timer_irq), 64'd0);

        // Carry from low to high half, then 64-bit wrap.
        axi_write(3'd1, 32'd0, 4'hF, 0);
        axi_write(3'd0, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(3'd1, 0, d1, r1);
        chk("carry_hi", 64'(d1), 64'd1);
        axi_write(3'd1, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(3'd0, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(3'd1, 0, d1, r1);
        chk("wrap_hi", 64'(d1), 64'd0);
        axi_read(3'd0, 0, d1, r1);

        // Partial strobe write; the increment is swallowed in the write cycle.
        tmp = mtime_m(cyc);
        old_lo = tmp[31:0];
        axi_write(3'd0, 32'h1234_5678, 4'b0011, 0);
        axi_read(3'd0, 0, d1, r1);
        chk("strb_low16", 64'(d1[15:0]), 64'h5679);
        chk("strb_up16", 64'(d1[31:16]), 64'(old_lo[31:16]));

        // Unmapped offset 6: SLVERR, no state change, reads as zero.
        axi_write(3'd6, 32'hDEAD_BEEF, 4'hF, 0);
        axi_read(3'd6, 0, d1, r1);
        chk("unmapped_rdata", 64'(d1), 64'd0);
        axi_read(3'd2, 0, d1, r1);
        axi_read(3'd4, 0, d1, r1);

        // Backpressure on both response channels.
        axi_write(3'd4, 32'd0, 4'hF, 5);
        axi_read(3'd0, 5, d1, r1);

        // Same-cycle read and write of MTIMECMP_LO returns the old value.
        tmp = cmp_m;
        bus.awaddr = 32'h8; bus.wdata = 32'h0000_0100; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.araddr = 32'h8; bus.arvalid = 1'b1;
        #1;
        chk("dual_awready", 64'(bus.awready), 64'd1);
        chk("dual_arready", 64'(bus.arready), 64'd1);
        model_write(3'd2, 32'h0000_0100, 4'hF, longint'(cyc));
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("dual_rdata", 64'(bus.rdata), 64'(tmp[31:0]));
        chk("dual_bvalid", 64'(bus.bvalid & bus.rvalid), 64'd1);
        bus.bready = 1'b1; bus.rready = 1'b1;
        step();
        bus.bready = 1'b0; bus.rready = 1'b0;
        axi_read(3'd2, 0, d1, r1);
        chk("dual_new", 64'(d1), 64'h100);

        // Random traffic against the model.
        for (int k = 0; k < 60; k++) begin
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                case (off)
                    3'd1, 3'd3: wd = $urandom_range(0, 1);
                    3'd2: begin tmp = mtime_m(cyc); wd = tmp[31:0] + $urandom_range(0, 60); end
                    3'd4: wd = $urandom_range(0, 5);
                    default: wd = $urandom;
                endcase
                axi_write(off, wd, 4'($urandom_range(1, 15)), $urandom_range(0, 3));
            end else begin
                axi_read(off, $urandom_range(0, 3), d1, r1);
            end
            idle($urandom_range(0, 4));
        end

        // Reset with both responses pending: they vanish and nothing is issued afterwards.
        bus.awaddr = 32'h0; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        model_write(3'd0, 32'h55, 4'hF, longint'(cyc));
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h0; bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        chk("mid_pending", 64'({bus.bvalid, bus.rvalid}), 64'd3);
        aresetn = 1'b0;
        step();
        chk("mid_bvalid", 64'(bus.bvalid), 64'd0);
        chk("mid_rvalid", 64'(bus.rvalid), 64'd0);
        chk("mid_irq", 64'(timer_irq), 64'd0);
        aresetn = 1'b1;
        model_reset();
        bus.bready = 1'b1; bus.rready = 1'b1;
        idle(3);
        chk("mid_quiet", 64'({bus.bvalid, bus.rvalid}), 64'd0);
        bus.bready = 1'b0; bus.rready = 1'b0;
        axi_read(3'd4, 0, d1, r1);
        chk("mid_prescale", 64'(d1), 64'd99);
        axi_read(3'd2, 0, d1, r1);
        chk("mid_cmp", 64'(d1), 64'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
